// File: rtl/ram_writer.sv
// ram_writer: packs an 8-bit byte stream into 32-bit little-endian words and
// writes them to a word-addressed RAM port starting at a base address.
// Partial words are written with byte-lane enables when the stream is flushed.
module ram_writer #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              flush,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_a,
  output logic [31:0]       ram_di,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [1:0]        r_lane;
  logic [3:0]        r_mask;
  logic [31:0]       r_data;
  logic              r_flushed;

  logic              w_xfer;
  logic              w_last_word;

  // A byte moves only while filling; din_ready is high for the whole FILL state.
  assign w_xfer      = (r_state == S_FILL) && din_valid;
  // The word being written is the last one the transfer asked for.
  assign w_last_word = (r_count == COUNT_ONE);

  // State register; reset forces IDLE at once so RAM strobes drop immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (word_count == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (w_xfer && (r_lane == 2'd3)) begin
          w_next = S_WRITE;
        end else if (flush) begin
          // Only bother the RAM if at least one lane holds data.
          w_next = (w_xfer || (r_mask != 4'h0)) ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: begin
        w_next = (w_last_word || r_flushed) ? S_DONE : S_FILL;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Transfer bookkeeping and word assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_lane    <= 2'd0;
      r_mask    <= 4'h0;
      r_data    <= 32'h0;
      r_flushed <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr    <= base_addr;
            r_count   <= word_count;
            r_lane    <= 2'd0;
            r_mask    <= 4'h0;
            r_data    <= 32'h0;
            r_flushed <= 1'b0;
          end
        end
        S_FILL: begin
          if (w_xfer) begin
            r_data[{r_lane, 3'b000} +: 8] <= din;
            r_mask[r_lane]                <= 1'b1;
            r_lane                        <= r_lane + 2'd1;
          end
          if (flush) begin
            r_flushed <= 1'b1;
          end
        end
        S_WRITE: begin
          // Clearing the data keeps unfilled lanes of a later partial word at zero.
          r_addr  <= r_addr + ADDR_ONE;
          r_count <= r_count - COUNT_ONE;
          r_lane  <= 2'd0;
          r_mask  <= 4'h0;
          r_data  <= 32'h0;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    din_ready = (r_state == S_FILL);
    ram_en    = (r_state == S_WRITE);
    ram_we    = (r_state == S_WRITE) ? r_mask : 4'h0;
    ram_a     = r_addr;
    ram_di    = r_data;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_ram_writer.sv
// Bench for ram_writer: directed and randomized transfers checked against a
// byte-list-to-word-list reference model of the expected RAM writes.
module tb_ram_writer;

  typedef struct packed {
    logic [4:0]  a;
    logic [3:0]  we;
    logic [31:0] di;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] word_count;
  logic       flush;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       ram_en;
  logic [3:0] ram_we;
  logic [4:0] ram_a;
  logic [31:0] ram_di;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  ram_writer #(.ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .flush      (flush),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_a      (ram_a),
    .ram_di     (ram_di),
    .busy       (busy),
    .done       (done)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int          done_cyc;
  logic [7:0]  tx[$];
  wr_t         obs[$];
  wr_t         exp_q[$];
  wr_t         saved[$];

  // Record every RAM write the block issues.
  always @(negedge clk) begin
    if (ram_en) obs.push_back({ram_a, ram_we, ram_di});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference: the consumed bytes grouped four at a time into consecutive words.
  task automatic build_exp(input logic [4:0] base, input int cnt, input bit do_flush);
    int nb;
    int used;
    int nw;
    int lanes;
    logic [31:0] di;
    logic [3:0]  we;
    nb   = tx.size();
    used = do_flush ? nb : 4 * cnt;
    if (used > nb) used = nb;
    nw = (used + 3) / 4;
    if (nw > cnt) nw = cnt;
    exp_q.delete();
    for (int w = 0; w < nw; w++) begin
      lanes = used - 4 * w;
      if (lanes > 4) lanes = 4;
      di = 32'h0;
      for (int k = 0; k < lanes; k++) di = di | (32'(tx[4 * w + k]) << (8 * k));
      we = 4'((1 << lanes) - 1);
      exp_q.push_back({5'(int'(base) + w), we, di});
    end
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwr"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      chk($sformatf("%s_wr%0d", tag, i), 64'(obs[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic run(input string tag, input logic [4:0] base, input int cnt,
                     input bit do_flush, input bit flush_last, input bit gaps, input bit stray);
    int nb;
    int idx;
    bit fl;
    bit fin;
    nb  = tx.size();
    idx = 0;
    fl  = 1'b0;
    fin = 1'b0;
    build_exp(base, cnt, do_flush);
    @(negedge clk);
    obs.delete();
    base_addr  = base;
    word_count = 6'(cnt);
    start      = 1'b1;
    din_valid  = 1'b0;
    flush      = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    done_cyc = -1;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      if (done) begin
        fin       = 1'b1;
        done_cyc  = cyc;
        start     = 1'b0;
        din_valid = 1'b0;
        flush     = 1'b0;
      end else begin
        din_valid = 1'b0;
        flush     = 1'b0;
        din       = 8'($urandom);
        if (stray) begin
          start      = 1'($urandom);
          base_addr  = 5'($urandom);
          word_count = 6'($urandom);
        end
        if (din_ready && idx < nb && (!gaps || $urandom_range(0, 1) == 1)) begin
          din       = tx[idx];
          din_valid = 1'b1;
          idx++;
          if (do_flush && flush_last && idx == nb) begin
            flush = 1'b1;
            fl    = 1'b1;
          end
        end else if (din_ready && idx == nb && do_flush && !fl) begin
          flush = 1'b1;
          fl    = 1'b1;
        end else if (!din_ready && gaps) begin
          flush = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    chk({tag, "_finished"}, 64'(fin), 64'd1);
    compare_writes(tag);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_ready_after"}, 64'(din_ready), 64'd0);
  endtask

  initial begin
    int cnt;
    int nb;
    bit fl;
    bit gp;
    logic [4:0] b;
    start = 1'b0; base_addr = '0; word_count = '0; flush = 1'b0;
    din = '0; din_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(din_ready), 64'd0);
    chk("rst_en", 64'(ram_en), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Two full words from base 3.
    tx = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    run("base3", 5'd3, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("base3_ex0", 64'(exp_q[0]), {23'd0, 5'd3, 4'hF, 32'h14131211});
    chk("base3_latency", 64'(done_cyc), 64'd10);

    // Address wrap 31 -> 0.
    tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run("wrap", 5'd31, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_ex1", 64'(exp_q[1]), {23'd0, 5'd0, 4'hF, 32'h08070605});

    // Partial word flushed after two bytes.
    tx = '{8'hAA, 8'hBB};
    run("flush2", 5'd9, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flush2_ex0", 64'(exp_q[0]), {23'd0, 5'd9, 4'h3, 32'h0000BBAA});

    // Zero-length transfer: done right away, no RAM access.
    tx.delete();
    run("cnt0", 5'd12, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cnt0_latency", 64'(done_cyc), 64'd0);

    // Flush at lane 0 after the first word.
    tx = '{8'h21, 8'h22, 8'h23, 8'h24};
    run("flush_l0", 5'd5, 3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush together with the third byte.
    tx = '{8'h31, 8'h32, 8'h33};
    run("flush_last", 5'd17, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("flush_last_ex0", 64'(exp_q[0]), {23'd0, 5'd17, 4'h7, 32'h00333231});

    // Gap-free versus gappy run with stray starts must write identically.
    tx.delete();
    for (int i = 0; i < 16; i++) tx.push_back(8'($urandom));
    b = 5'($urandom);
    run("gapless", b, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    saved = obs;
    run("gappy", b, 4, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("gappy_same_n", 64'(obs.size()), 64'(saved.size()));
    for (int i = 0; i < saved.size() && i < obs.size(); i++)
      chk($sformatf("gappy_same%0d", i), 64'(obs[i]), 64'(saved[i]));

    // Full 32-word transfer at full throughput.
    tx.delete();
    for (int i = 0; i < 128; i++) tx.push_back(8'($urandom));
    run("cnt32", 5'($urandom), 32, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cnt32_latency", 64'(done_cyc), 64'd160);

    // Random transfers.
    for (int t = 0; t < 6; t++) begin
      cnt = $urandom_range(1, 8);
      fl  = 1'($urandom);
      gp  = 1'($urandom);
      nb  = fl ? $urandom_range(0, 4 * cnt) : 4 * cnt;
      tx.delete();
      for (int i = 0; i < nb; i++) tx.push_back(8'($urandom));
      run($sformatf("rand%0d", t), 5'($urandom), cnt, fl, 1'b0, gp, gp);
    end

    // Reset during a WRITE cycle.
    @(negedge clk);
    base_addr = 5'd7; word_count = 6'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din = 8'(8'h40 + k);
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    chk("rstw_in_write", 64'(ram_en), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstw_en", 64'(ram_en), 64'd0);
    chk("rstw_we", 64'(ram_we), 64'd0);
    chk("rstw_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tx = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};
    run("after_rst", 5'd20, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
